// File: rtl/bvashr_ugt_skolem_seq_if.sv
// bvashr_ugt_skolem_seq_if: request/result bundle for the sequential bvashr/bvugt witness search
// master drives start, pos_sel, s_in, t_in; slave returns busy, done, found, x_out
interface bvashr_ugt_skolem_seq_if #(parameter int W = 4);
  logic         start;
  logic         pos_sel;
  logic [W-1:0] s_in;
  logic [W-1:0] t_in;
  logic         busy;
  logic         done;
  logic         found;
  logic [W-1:0] x_out;
  modport master (output start, pos_sel, s_in, t_in, input busy, done, found, x_out);
  modport slave (input start, pos_sel, s_in, t_in, output busy, done, found, x_out);
endinterface

// File: rtl/bvashr_ugt_skolem_seq.sv
// bvashr_ugt_skolem_seq: sequential minimal-witness search for (s >>a x) >u t or (x >>a s) >u t
// clk, rst_n (async active-low); bus.slave: start/pos_sel/s_in/t_in in, busy/done/found/x_out out
module bvashr_ugt_skolem_seq #(
  parameter int W  = 4,
  parameter int CW = W + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bvashr_ugt_skolem_seq_if.slave       bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  localparam logic [CW-1:0] LAST_SHIFT = CW'(W - 1);
  localparam logic [CW-1:0] LAST_VALUE = CW'((2 ** W) - 1);
  localparam logic [W-1:0]  MAX_AMT    = W'(W - 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  s_r, t_r, x_r;
  logic          ps_r, busy_r, done_r, found_r;
  logic [W-1:0]  k, val, amt, amt_c, sh;
  logic          hit, last;
  // pos_sel=0 shifts s by k; pos_sel=1 shifts candidate k by s
  assign k     = cnt[W-1:0];
  assign val   = ps_r ? k : s_r;
  assign amt   = ps_r ? s_r : k;
  // amounts past W-1 saturate to all sign bits
  assign amt_c = (amt > MAX_AMT) ? MAX_AMT : amt;
  assign sh    = $signed(val) >>> amt_c;
  assign hit   = sh > t_r;
  assign last  = ps_r ? (cnt == LAST_VALUE) : (cnt == LAST_SHIFT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      s_r     <= '0;
      t_r     <= '0;
      ps_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      found_r <= 1'b0;
      x_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            s_r     <= bus.s_in;
            t_r     <= bus.t_in;
            ps_r    <= bus.pos_sel;
            cnt     <= '0;
            found_r <= 1'b0;
            x_r     <= '0;
            busy_r  <= 1'b1;
            state   <= SEARCH;
          end
        end
        SEARCH: begin
          // the end-of-range test comes before the increment so cnt never wraps
          if (hit || last) begin
            found_r <= hit;
            x_r     <= hit ? k : '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.found = found_r;
  assign bus.x_out = x_r;
endmodule
